// File: rtl/trace_cmd_queue_pkg.sv
// Shared opcode encodings, command classes and default address-split widths
// for the trace command queue.
package trace_cmd_queue_pkg;

    localparam int unsigned OFFSET_W_DEF = 6;
    localparam int unsigned INDEX_W_DEF  = 14;

    typedef enum logic [3:0] {
        OP_RD_L1    = 4'd0,
        OP_WR_L1    = 4'd1,
        OP_IFETCH   = 4'd2,
        OP_INV_L2   = 4'd3,
        OP_SNP_RD   = 4'd4,
        OP_SNP_WR   = 4'd5,
        OP_SNP_RWIM = 4'd6,
        OP_SNP_INV  = 4'd7,
        OP_CLEAR    = 4'd8,
        OP_PRINT    = 4'd9
    } trace_op_e;

    typedef enum logic [2:0] {
        CLS_RD,
        CLS_WR,
        CLS_SNOOP,
        CLS_CLEAR,
        CLS_PRINT,
        CLS_BAD
    } op_class_e;

    function automatic op_class_e classify(input logic [3:0] op);
        op_class_e cls;
        case (op)
            OP_RD_L1, OP_IFETCH:                                     cls = CLS_RD;
            OP_WR_L1:                                                cls = CLS_WR;
            OP_INV_L2, OP_SNP_RD, OP_SNP_WR, OP_SNP_RWIM, OP_SNP_INV: cls = CLS_SNOOP;
            OP_CLEAR:                                                cls = CLS_CLEAR;
            OP_PRINT:                                                cls = CLS_PRINT;
            default:                                                 cls = CLS_BAD;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/trace_cmd_queue_if.sv
// Command handshake bundle: parser-side input channel and cache-side output
// channel with the head address already split into tag/index/offset.
interface trace_cmd_queue_if #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned OFFSET_W = 6,
    parameter int unsigned INDEX_W  = 14
);
    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    logic                in_valid;
    logic                in_ready;
    logic [3:0]          in_opcode;
    logic [ADDR_W-1:0]   in_addr;
    logic                out_valid;
    logic                out_ready;
    logic [3:0]          out_op;
    logic [TAG_W-1:0]    out_tag;
    logic [INDEX_W-1:0]  out_index;
    logic [OFFSET_W-1:0] out_offset;

    modport master (
        output in_valid, in_opcode, in_addr, out_ready,
        input  in_ready, out_valid, out_op, out_tag, out_index, out_offset
    );

    modport slave (
        input  in_valid, in_opcode, in_addr, out_ready,
        output in_ready, out_valid, out_op, out_tag, out_index, out_offset
    );

endinterface

// File: rtl/trace_cmd_queue_sync_fifo.sv
// Power-of-two synchronous FIFO: storage, wrapping pointers and occupancy.
module sync_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/trace_cmd_queue.sv
// Trace command queue: validates opcodes, buffers commands in order, splits
// the head address for the LLC controller and keeps per-class statistics.
module trace_cmd_queue
    import trace_cmd_queue_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned OFFSET_W = OFFSET_W_DEF,
    parameter int unsigned INDEX_W  = INDEX_W_DEF,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    trace_cmd_queue_if.slave       cmd,
    output logic                   clear_pulse_o,
    output logic                   print_pulse_o,
    output logic                   bad_op_pulse_o,
    output logic [CNT_W-1:0]       rd_count_o,
    output logic [CNT_W-1:0]       wr_count_o,
    output logic [CNT_W-1:0]       snoop_count_o,
    output logic [CNT_W-1:0]       bad_count_o,
    output logic [$clog2(DEPTH):0] fifo_count_o
);
    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned ENTRY_W = 4 + ADDR_W;

    logic               full, empty;
    logic               accept, bad_accept, push, dequeue;
    logic [ENTRY_W-1:0] head;
    logic [3:0]         head_op;
    logic [ADDR_W-1:0]  head_addr;
    op_class_e          in_cls, head_cls;

    logic [CNT_W-1:0] rd_q, rd_d, wr_q, wr_d, snp_q, snp_d, badc_q, badc_d;
    logic             clr_q, clr_d, prt_q, prt_d, badp_q, badp_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign cmd.in_ready = !full && !rst;
    assign in_cls       = classify(cmd.in_opcode);
    assign accept       = cmd.in_valid && cmd.in_ready;
    assign bad_accept   = accept && (in_cls == CLS_BAD);
    assign push         = accept && (in_cls != CLS_BAD);
    assign dequeue      = !empty && cmd.out_ready;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (dequeue),
        .wdata_i ({cmd.in_opcode, cmd.in_addr}),
        .rdata_o (head),
        .count_o (fifo_count_o),
        .full_o  (full),
        .empty_o (empty)
    );

    assign head_op        = head[ENTRY_W-1 -: 4];
    assign head_addr      = head[ADDR_W-1:0];
    assign head_cls       = classify(head_op);
    assign cmd.out_valid  = !empty;
    assign cmd.out_op     = head_op;
    assign cmd.out_tag    = head_addr[ADDR_W-1 -: TAG_W];
    assign cmd.out_index  = head_addr[OFFSET_W +: INDEX_W];
    assign cmd.out_offset = head_addr[OFFSET_W-1:0];

    // Dequeue-side statistics and accept-side bad-opcode tracking are
    // independent, so both may update in the same cycle.
    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        snp_d  = snp_q;
        badc_d = badc_q;
        clr_d  = 1'b0;
        prt_d  = 1'b0;
        badp_d = bad_accept;
        if (dequeue) begin
            case (head_cls)
                CLS_RD:    rd_d  = sat_inc(rd_q);
                CLS_WR:    wr_d  = sat_inc(wr_q);
                CLS_SNOOP: snp_d = sat_inc(snp_q);
                CLS_CLEAR: begin
                    rd_d  = '0;
                    wr_d  = '0;
                    snp_d = '0;
                    clr_d = 1'b1;
                end
                CLS_PRINT: prt_d = 1'b1;
                default:   ;
            endcase
        end
        if (bad_accept) badc_d = sat_inc(badc_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            snp_q  <= '0;
            badc_q <= '0;
            clr_q  <= 1'b0;
            prt_q  <= 1'b0;
            badp_q <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            snp_q  <= snp_d;
            badc_q <= badc_d;
            clr_q  <= clr_d;
            prt_q  <= prt_d;
            badp_q <= badp_d;
        end
    end

    assign rd_count_o     = rd_q;
    assign wr_count_o     = wr_q;
    assign snoop_count_o  = snp_q;
    assign bad_count_o    = badc_q;
    assign clear_pulse_o  = clr_q;
    assign print_pulse_o  = prt_q;
    assign bad_op_pulse_o = badp_q;

endmodule

// File: tb/tb_trace_cmd_queue.sv
// Scoreboard bench for trace_cmd_queue: the driver records expected commands
// and bad-opcode effects, a negedge monitor checks every output cycle.
module tb_trace_cmd_queue;
    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_pulse, print_pulse, bad_op_pulse;
    logic [31:0] rd_count, wr_count, snoop_count, bad_count;
    logic [3:0]  fifo_count;

    always #5 clk = ~clk;

    trace_cmd_queue_if #(.ADDR_W(32), .OFFSET_W(6), .INDEX_W(14)) bus ();

    trace_cmd_queue #(
        .ADDR_W   (32),
        .OFFSET_W (6),
        .INDEX_W  (14),
        .DEPTH    (DEPTH),
        .CNT_W    (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd            (bus),
        .clear_pulse_o  (clear_pulse),
        .print_pulse_o  (print_pulse),
        .bad_op_pulse_o (bad_op_pulse),
        .rd_count_o     (rd_count),
        .wr_count_o     (wr_count),
        .snoop_count_o  (snoop_count),
        .bad_count_o    (bad_count),
        .fifo_count_o   (fifo_count)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
    } cmd_t;

    cmd_t        exp_q[$];
    int unsigned m_rd = 0, m_wr = 0, m_snp = 0, m_bad = 0;
    bit          exp_clr = 0, exp_prt = 0, exp_badp = 0;
    int          total = 0, bad = 0;
    cmd_t        mc;
    int unsigned mn;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    // Monitor: outputs reflect the state after the preceding rising edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_pulses", {clear_pulse, print_pulse, bad_op_pulse}, 0);
        end else begin
            mn = exp_q.size();
            chk("in_ready", bus.in_ready, mn < DEPTH);
            chk("out_valid", bus.out_valid, mn != 0);
            chk("fifo_count", fifo_count, mn);
            chk("rd_count", rd_count, m_rd);
            chk("wr_count", wr_count, m_wr);
            chk("snoop_count", snoop_count, m_snp);
            chk("bad_count", bad_count, m_bad);
            chk("clear_pulse", clear_pulse, exp_clr);
            chk("print_pulse", print_pulse, exp_prt);
            chk("bad_op_pulse", bad_op_pulse, exp_badp);
            exp_clr = 0;
            exp_prt = 0;
            if (mn != 0 && bus.out_ready) begin
                mc = exp_q.pop_front();
                chk("out_op", bus.out_op, mc.op);
                chk("out_tag", bus.out_tag, mc.addr / 32'h0010_0000);
                chk("out_index", bus.out_index, (mc.addr / 64) % 16384);
                chk("out_offset", bus.out_offset, mc.addr % 64);
                if (mc.op == 0 || mc.op == 2)  m_rd  = sat(m_rd);
                else if (mc.op == 1)           m_wr  = sat(m_wr);
                else if (mc.op <= 7)           m_snp = sat(m_snp);
                else if (mc.op == 8) begin
                    m_rd = 0; m_wr = 0; m_snp = 0;
                    exp_clr = 1;
                end else                       exp_prt = 1;
            end
        end
    end

    // Called at posedge+1; drives one cycle and records its expected effect.
    task automatic cycle(input bit v, input logic [3:0] op, input logic [31:0] a, input bit ordy);
        bit acc;
        bus.in_valid  = v;
        bus.in_opcode = op;
        bus.in_addr   = a;
        bus.out_ready = ordy;
        acc = v && (exp_q.size() < DEPTH);
        @(posedge clk);
        #1;
        exp_badp = 0;
        if (acc) begin
            if (op <= 9) exp_q.push_back('{op: op, addr: a});
            else begin
                m_bad    = sat(m_bad);
                exp_badp = 1;
            end
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(0, 4'd0, 32'd0, ordy);
    endtask

    task automatic do_reset();
        bus.in_valid  = 0;
        bus.out_ready = 0;
        #3;
        rst = 1'b1;
        #1;
        chk("async_out_valid", bus.out_valid, 0);
        chk("async_fifo_count", fifo_count, 0);
        chk("async_in_ready", bus.in_ready, 0);
        exp_q.delete();
        m_rd = 0; m_wr = 0; m_snp = 0; m_bad = 0;
        exp_clr = 0; exp_prt = 0; exp_badp = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 0;
        bus.in_opcode = '0;
        bus.in_addr   = '0;
        bus.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single command, visible one cycle after acceptance.
        cycle(1, 4'd0, 32'h0ABC_DE7F, 0);
        chk("t1_fifo_count", fifo_count, 1);
        idle(1, 0);
        idle(2, 1);

        // Fill to full, ninth held off, drain, then refill across the wrap.
        for (int i = 0; i < 9; i++) cycle(1, 4'(i % 8), 32'h1000_0000 + 32'(i * 64), 0);
        chk("t2_full_count", fifo_count, DEPTH);
        cycle(1, 4'd1, 32'hDEAD_BEEF, 1);
        idle(10, 1);
        for (int i = 0; i < 5; i++) cycle(1, 4'(i), $urandom, 0);
        idle(6, 1);

        // Statistics stream ending in a print.
        cycle(1, 4'd0, $urandom, 0);
        cycle(1, 4'd1, $urandom, 0);
        cycle(1, 4'd2, $urandom, 0);
        cycle(1, 4'd4, $urandom, 0);
        cycle(1, 4'd9, $urandom, 0);
        idle(7, 1);

        // Bad opcode, then clear; bad with simultaneous dequeue.
        cycle(1, 4'd12, $urandom, 0);
        cycle(1, 4'd8, $urandom, 0);
        cycle(1, 4'd15, $urandom, 1);
        idle(3, 1);

        // Steady state at occupancy 3.
        for (int i = 0; i < 3; i++) cycle(1, 4'(i + 3), $urandom, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 4'($urandom_range(0, 9)), $urandom, 1);
            chk("t5_steady_count", fifo_count, 3);
        end
        idle(5, 1);

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 5; i++) cycle(1, 4'(i), $urandom, 0);
        do_reset();
        idle(2, 1);

        // Randomised traffic with varying back-pressure.
        for (int seg = 0; seg < 8; seg++) begin
            int unsigned rdy_pct = $urandom_range(10, 90);
            for (int i = 0; i < 50; i++) begin
                logic [3:0] op;
                op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
                cycle($urandom_range(0, 3) != 0, op, $urandom,
                      $urandom_range(1, 100) <= rdy_pct);
            end
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1, 1);
        idle(2, 1);
        chk("final_empty", fifo_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
